seq_detector_param: RTL and testbench

//  Parametrised serial pattern detector; successor to the fixed 4-bit FSM detector.
//  - Pattern and length are runtime-programmable, up to PAT_W bits.
//  - Runtime choice of overlapping or non-overlapping matching.
//  - Input qualified by a valid strobe; optional saturating match counter.
//  - Sits on a 1-bit serial stream and pulses on each pattern match.

---
 rtl/seq_det_pkg.sv | 25 ++
 rtl/seq_det_if.sv | 30 +++
 rtl/seq_det_window.sv | 46 ++++
 rtl/seq_detector_param.sv | 107 ++++++++++
 tb/tb_seq_detector_param.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and types for the parametrised serial pattern detector.
// Optional feature macro: SEQ_MATCH_CNT_EN (enables the saturating match counter).
package seq_det_pkg;

  // Default maximum pattern length and the matching length-field width.
  localparam int unsigned PAT_W_DEF = 4;
  localparam int unsigned LEN_W     = $clog2(PAT_W_DEF + 1);

  // Overlap-mode encodings for the active configuration.
  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_mode_e;

  // Reset values of the active configuration.
  localparam logic      RST_PATTERN_BIT = 1'b0;
  localparam int unsigned RST_LEN       = 0;
  localparam ovl_mode_e RST_OVERLAP     = OVL_ON;

  // Width of a length/fill field for a given maximum pattern length.
  function automatic int unsigned len_width(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_if.sv
// Stream, configuration and result signals of the serial pattern detector.
// The counter output is only meaningful when SEQ_MATCH_CNT_EN is defined.
interface seq_det_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);
  import seq_det_pkg::*;

  localparam int unsigned L_W = len_width(PAT_W);

  logic             in_valid;
  logic             in_bit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [L_W-1:0]   cfg_len;
  logic             cfg_overlap;
  logic             detected;
  logic [CNT_W-1:0] match_count;

  modport master (
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  detected, match_count
  );

  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output detected, match_count
  );

endinterface

// File: rtl/seq_det_window.sv
// Serial history window plus saturating fill counter for the pattern detector.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  localparam int unsigned L_W  = len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             flush,
  input  logic             fill_clr,
  input  logic             in_bit,
  output logic [PAT_W-1:0] window,
  output logic [L_W-1:0]   fill
);

  logic [PAT_W-1:0] window_q;
  logic [L_W-1:0]   fill_q;

  // Shift in qualified bits; flush or reset wipe all history.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      window_q <= '0;
    end else if (shift_en) begin
      window_q <= {window_q[PAT_W-2:0], in_bit};
    end
  end

  // Count valid bits seen, saturating at PAT_W; a non-overlap match restarts it.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      fill_q <= '0;
    end else if (shift_en) begin
      if (fill_clr) begin
        fill_q <= '0;
      end else if (fill_q < L_W'(PAT_W)) begin
        fill_q <= fill_q + L_W'(1);
      end
    end
  end

  assign window = window_q;
  assign fill   = fill_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control.
// Define SEQ_MATCH_CNT_EN to build the saturating match counter; otherwise
// match_count is tied to zero and no counter flops exist.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic     clk,
  input logic     reset,
  seq_det_if.slave bus
);

  localparam int unsigned L_W = len_width(PAT_W);

  logic [PAT_W-1:0] act_pattern;
  logic [L_W-1:0]   act_len;
  ovl_mode_e        act_overlap;
  logic [L_W-1:0]   len_clamped_c;

  logic [PAT_W-1:0] window;
  logic [L_W-1:0]   fill;

  logic             shift_en_c;
  logic             fill_ok_c;
  logic             pat_eq_c;
  logic             match_c;
  logic [PAT_W:0]   cand_c;
  logic [PAT_W:0]   pat_ext_c;
  logic [PAT_W:0]   mask_c;
  logic             detected_q;

  // Over-long lengths are clamped to the window size when latched.
  assign len_clamped_c = (bus.cfg_len > L_W'(PAT_W)) ? L_W'(PAT_W) : bus.cfg_len;

  // Active configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_pattern <= {PAT_W{RST_PATTERN_BIT}};
      act_len     <= L_W'(RST_LEN);
      act_overlap <= RST_OVERLAP;
    end else if (bus.cfg_load) begin
      act_pattern <= bus.cfg_pattern;
      act_len     <= len_clamped_c;
      act_overlap <= ovl_mode_e'(bus.cfg_overlap);
    end
  end

  // A config load takes priority over, and discards, a same-cycle input bit.
  assign shift_en_c = bus.in_valid && !bus.cfg_load;

  seq_det_window #(
    .PAT_W (PAT_W)
  ) u_window (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en_c),
    .flush    (bus.cfg_load),
    .fill_clr (match_c && (act_overlap == OVL_OFF)),
    .in_bit   (bus.in_bit),
    .window   (window),
    .fill     (fill)
  );

  // Masked compare of the incoming bit plus history against the active pattern.
  always_comb begin
    cand_c    = {window, bus.in_bit};
    pat_ext_c = {1'b0, act_pattern};
    mask_c    = '0;
    for (int unsigned i = 0; i <= PAT_W; i++) begin
      mask_c[i] = (i < 32'(act_len));
    end
    pat_eq_c  = (((cand_c ^ pat_ext_c) & mask_c) == '0);
    fill_ok_c = ((L_W + 1)'(fill) + (L_W + 1)'(1)) >= (L_W + 1)'(act_len);
    match_c   = shift_en_c && (act_len != '0) && fill_ok_c && pat_eq_c;
  end

  // One-cycle match pulse, registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      detected_q <= 1'b0;
    end else begin
      detected_q <= match_c;
    end
  end

  assign bus.detected = detected_q;

`ifdef SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] count_q;

  // Saturating match counter, updated on the same edge as the pulse.
  always_ff @(posedge clk) begin
    if (reset || bus.cfg_load) begin
      count_q <= '0;
    end else if (match_c && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.match_count = count_q;
`else
  assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (PAT_W=4, CNT_W=2).
// Expected counter values follow SEQ_MATCH_CNT_EN: saturating at 3 when defined, 0 otherwise.
module tb_seq_detector_param;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 2;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   chk_cnt;

  seq_det_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value after n matches since the last clear.
  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
`ifdef SEQ_MATCH_CNT_EN
    return (n > 3) ? 2'd3 : CNT_W'(n);
`else
    return (n > 0) ? 2'd0 : 2'd0;
`endif
  endfunction

  // One clock of stream input; outputs are read 1 time unit after the edge.
  task automatic send(input logic v, input logic b);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_bit   = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Load a configuration; a valid bit is driven alongside to show it is dropped.
  task automatic load_cfg(input logic [3:0] pat, input logic [2:0] len, input logic ovl);
    @(negedge clk);
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    bus.in_valid    = 1'b1;
    bus.in_bit      = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_load = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    chk_cnt++;
    if (bus.detected !== 1'b0) $display("FAIL reset_detected got=%b exp=0", bus.detected);
    else pass_cnt++;
    chk_cnt++;
    if (bus.match_count !== 2'd0) $display("FAIL reset_count got=%0d exp=0", bus.match_count);
    else pass_cnt++;
    // Power-up config has len=0, so a stream of ones must never match.
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b1);
      chk_cnt++;
      if (bus.detected !== 1'b0) $display("FAIL reset_disabled_bit%0d got=%b exp=0", i, bus.detected);
      else pass_cnt++;
    end
  endtask

  task automatic run_stream(input string name, input logic [6:0] bits, input logic [6:0] exp);
    for (int i = 6; i >= 0; i--) begin
      send(1'b1, bits[i]);
      chk_cnt++;
      if (bus.detected !== exp[i])
        $display("FAIL %s_bit%0d detected=%b exp=%b", name, 7 - i, bus.detected, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_overlap();
    load_cfg(4'b1011, 3'd4, 1'b1);
    run_stream("overlap", 7'b1011011, 7'b0001001);
    chk_cnt++;
    if (bus.match_count !== exp_cnt(2)) $display("FAIL overlap_count got=%0d exp=%0d", bus.match_count, exp_cnt(2));
    else pass_cnt++;
  endtask

  task automatic test_no_overlap();
    load_cfg(4'b1011, 3'd4, 1'b0);
    chk_cnt++;
    if (bus.match_count !== 2'd0) $display("FAIL noovl_count_clear got=%0d exp=0", bus.match_count);
    else pass_cnt++;
    run_stream("noovl", 7'b1011011, 7'b0001000);
    chk_cnt++;
    if (bus.match_count !== exp_cnt(1)) $display("FAIL noovl_count got=%0d exp=%0d", bus.match_count, exp_cnt(1));
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    logic [3:0] bits;
    bits = 4'b1011;
    load_cfg(4'b1011, 3'd4, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      send(1'b1, bits[i]);
      chk_cnt++;
      if (bus.detected !== (i == 0)) $display("FAIL gaps_bit%0d detected=%b exp=%b", 4 - i, bus.detected, (i == 0));
      else pass_cnt++;
      for (int g = 0; g < 3; g++) begin
        send(1'b0, 1'b1);
        chk_cnt++;
        if (bus.detected !== 1'b0) $display("FAIL gaps_idle%0d_%0d detected=%b exp=0", 4 - i, g, bus.detected);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_length();
    load_cfg(4'b0011, 3'd2, 1'b1);
    run_stream("len2", 7'b0000111, 7'b0000011);
    load_cfg(4'b0000, 3'd0, 1'b1);
    run_stream("len0", 7'b0000010, 7'b0000000);
    // len=7 clamps to 4: only a full four-bit match may fire.
    load_cfg(4'b1011, 3'd7, 1'b1);
    run_stream("clamp", 7'b0001011, 7'b0000001);
  endtask

  task automatic test_midstream_load();
    load_cfg(4'b1011, 3'd4, 1'b1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    load_cfg(4'b1011, 3'd4, 1'b1);
    send(1'b1, 1'b1);
    chk_cnt++;
    if (bus.detected !== 1'b0) $display("FAIL midload_detected got=%b exp=0", bus.detected);
    else pass_cnt++;
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    chk_cnt++;
    if (bus.detected !== 1'b1) $display("FAIL midload_fresh_match got=%b exp=1", bus.detected);
    else pass_cnt++;
  endtask

  task automatic test_midstream_reset();
    load_cfg(4'b1011, 3'd4, 1'b1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    do_reset(1);
    send(1'b1, 1'b1);
    chk_cnt++;
    if (bus.detected !== 1'b0) $display("FAIL midreset_detected got=%b exp=0", bus.detected);
    else pass_cnt++;
    // Reloading after reset must still start from an empty window.
    load_cfg(4'b1011, 3'd4, 1'b1);
    send(1'b1, 1'b1);
    chk_cnt++;
    if (bus.detected !== 1'b0) $display("FAIL midreset_reload got=%b exp=0", bus.detected);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    load_cfg(4'b0001, 3'd1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      send(1'b1, 1'b1);
      chk_cnt++;
      if (bus.detected !== 1'b1) $display("FAIL b2b_detected%0d got=%b exp=1", i, bus.detected);
      else pass_cnt++;
      chk_cnt++;
      if (bus.match_count !== exp_cnt(i)) $display("FAIL b2b_count%0d got=%0d exp=%0d", i, bus.match_count, exp_cnt(i));
      else pass_cnt++;
    end
    send(1'b0, 1'b1);
    chk_cnt++;
    if (bus.detected !== 1'b0) $display("FAIL b2b_idle got=%b exp=0", bus.detected);
    else pass_cnt++;
    chk_cnt++;
    if (bus.match_count !== exp_cnt(5)) $display("FAIL b2b_hold got=%0d exp=%0d", bus.match_count, exp_cnt(5));
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt        = 0;
    chk_cnt         = 0;
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_bit      = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b1;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_gaps();
    test_length();
    test_midstream_load();
    test_midstream_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
